multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle variant of the simple CPU. It sequences one shared ALU, one unified instruction/data memory and the register file through fetch, decode, execute, memory and writeback steps. It waits on a memory-ready handshake and counts retired instructions for the test bench. On an unsupported opcode it halts the core.

Parameters:
CNT_W, 32, width of retired-instruction and cycle counters

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
opcode_i  in  6  IR[31:26] from instruction register
zero_i  in  1  ALU zero flag, used only for debug/branch_taken_o
mem_ready_i  in  1  memory completes access this cycle
pc_write_o  out  1  unconditional PC load
pc_write_cond_o  out  1  PC load if zero_i
i_or_d_o  out  1  memory address select: 0=PC, 1=ALUOut
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
ir_write_o  out  1  instruction register load
mem_to_reg_o  out  1  writeback source: 0=ALUOut, 1=MDR
reg_dst_o  out  1  write register: 0=rt, 1=rd
reg_write_o  out  1  register file write enable
alu_src_a_o  out  1  0=PC, 1=reg A
alu_src_b_o  out  2  00=B, 01=4, 10=sext imm, 11=sext imm<<2
alu_op_o  out  2  00=add, 01=sub, 10=use funct, 11=slt
pc_source_o  out  2  00=ALU result, 01=ALUOut, 10=jump target
state_o  out  4  current state, for debug
instr_done_o  out  1  one-cycle pulse on last cycle of each instruction
halted_o  out  1  sticky illegal-opcode halt
retired_o  out  CNT_W  retired instruction count
cycles_o  out  CNT_W  cycles since reset, frozen while halted

Behaviour:
- Reset: state=FETCH, retired_o=0, cycles_o=0, halted_o=0. All control outputs are forced 0 while rst_i=1.
- Reset mid-instruction aborts the instruction; no write is issued in the reset cycle.
- Moore FSM with 4-bit encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, HALT=12.
- Control outputs are decoded combinationally from state. The only exception: writes in memory states are gated by mem_ready_i.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write assert only when mem_ready_i=1, which also moves to DECODE. Otherwise stay in FETCH with mem_read held.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 or 001010 -> I_EXEC
  - any other opcode -> HALT
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready_i, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Retires; next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1. mem_write stays asserted until mem_ready_i=1, then retires and goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retires.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 for addi, 11 for slti. Next state I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Retires.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retires.
- JUMP: pc_write=1, pc_source=10. Retires.
- Retire means instr_done_o=1 for that cycle and retired_o increments at the clock edge. retired_o and cycles_o wrap modulo 2^CNT_W.
- Opcode is sampled only in DECODE and MEM_ADDR; IR is stable there.
- HALT: all control outputs 0, halted_o=1, no retire, cycles_o frozen. Only reset exits HALT.
- CPI with mem_ready_i tied 1: lw=5, sw=4, R=4, addi/slti=4, beq=3, j=3.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encodings
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI
  - ALUOp, ALUSrcB and PCSource encodings
- The same package is used by the ALU control and the datapath.
- Natural sub-module: ctrl_decode, a pure combinational state -> control-vector decoder. The FSM and counters stay in the top.

Test Plan:
- Reset held 3 cycles, then released with mem_ready_i=1 and opcode=000000 -> state sequence 0,1,6,7,0. instr_done_o high in the R_WB cycle. retired_o=1 after 4 cycles.
- opcode=100011 with mem_ready_i low for 2 cycles in MEM_RD -> state stays 3 for 3 cycles with mem_read=1, i_or_d=1. Then MEM_WB has reg_write=1, mem_to_reg=1. Total 7 cycles.
- opcode=101011 -> MEM_WR asserts mem_write=1 until mem_ready_i. reg_write never asserts. Retire takes 4 cycles.
- opcode=000100 and 000010 alternating 10 times -> each takes 3 cycles; retired_o=20 and cycles_o=60 at the end. BRANCH shows pc_write_cond=1, alu_op=01; JUMP shows pc_source=10.
- opcode=111111 -> DECODE goes to HALT(12) with halted_o=1. Outputs stay 0 and cycles_o is frozen for 20 cycles. Asserting rst_i returns to FETCH and clears halted_o.
- Assert rst_i during R_EXEC -> next state FETCH, counters 0, reg_write never pulses.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle CPU control path.
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_HALT     = 4'd12
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       done;
  } ctrl_t;
  function automatic state_t op_to_state(input logic [5:0] op);
    return op == OP_RTYPE                ? S_R_EXEC   :
           (op == OP_LW || op == OP_SW)   ? S_MEM_ADDR :
           op == OP_BEQ                   ? S_BRANCH   :
           op == OP_J                     ? S_JUMP     :
           (op == OP_ADDI || op == OP_SLTI) ? S_I_EXEC : S_HALT;
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational state -> control-vector decoder.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  input  logic   i_slti,
  output ctrl_t  o_ctrl
);
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: o_ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.done       = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
        o_ctrl.done      = i_mem_ready;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.done      = 1'b1;
      end
      S_I_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = i_slti ? ALU_SLT : ALU_ADD;
      end
      S_I_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.done      = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.done          = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
        o_ctrl.done      = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle CPU with retire/cycle counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             mem_to_reg_o,
  output logic             reg_dst_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic             instr_done_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [CNT_W-1:0] cycles_o
);
  state_t           r_state;
  logic             r_slti;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_cycles;
  ctrl_t            w_ctrl;
  ctrl_t            w_out;
  logic             w_unused_zero;
  assign w_unused_zero = zero_i;
  ctrl_decode u_decode (
    .i_state    (r_state),
    .i_mem_ready(mem_ready_i),
    .i_slti     (r_slti),
    .o_ctrl     (w_ctrl)
  );
  // Reset blanks every control so an aborted instruction issues no write.
  assign w_out = rst_i ? '0 : w_ctrl;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_FETCH;
      r_slti    <= 1'b0;
      r_retired <= '0;
      r_cycles  <= '0;
    end else begin
      if (r_state != S_HALT) r_cycles <= r_cycles + 1'b1;
      if (w_ctrl.done) r_retired <= r_retired + 1'b1;
      case (r_state)
        S_FETCH:    r_state <= mem_ready_i ? S_DECODE : S_FETCH;
        S_DECODE: begin
          r_slti  <= opcode_i == OP_SLTI;
          r_state <= op_to_state(opcode_i);
        end
        S_MEM_ADDR: r_state <= opcode_i == OP_SW ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   r_state <= mem_ready_i ? S_MEM_WB : S_MEM_RD;
        S_MEM_WR:   r_state <= mem_ready_i ? S_FETCH : S_MEM_WR;
        S_R_EXEC:   r_state <= S_R_WB;
        S_I_EXEC:   r_state <= S_I_WB;
        S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: r_state <= S_FETCH;
        default:    r_state <= S_HALT;
      endcase
    end
  end
  assign pc_write_o      = w_out.pc_write;
  assign pc_write_cond_o = w_out.pc_write_cond;
  assign i_or_d_o        = w_out.i_or_d;
  assign mem_read_o      = w_out.mem_read;
  assign mem_write_o     = w_out.mem_write;
  assign ir_write_o      = w_out.ir_write;
  assign mem_to_reg_o    = w_out.mem_to_reg;
  assign reg_dst_o       = w_out.reg_dst;
  assign reg_write_o     = w_out.reg_write;
  assign alu_src_a_o     = w_out.alu_src_a;
  assign alu_src_b_o     = w_out.alu_src_b;
  assign alu_op_o        = w_out.alu_op;
  assign pc_source_o     = w_out.pc_source;
  assign instr_done_o    = w_out.done;
  assign state_o         = r_state;
  assign halted_o        = r_state == S_HALT;
  assign retired_o       = r_retired;
  assign cycles_o        = r_cycles;
endmodule
